// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding and word-alignment constants.
package mem_access_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam int DATA_W_DEF    = 32;
  localparam int WORD_OFF_BITS = 2;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB pipeline register. A bubble clears the writeback controls and holds the payload fields.
module mem_wb
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble_i,
  input  logic              ld_data_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [4:0]        rd_i,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [4:0]        rd_o,
  output logic              reg_write_o,
  output logic              mem_to_reg_o
);

  logic [DATA_W-1:0] alu_result_q, mem_data_q;
  logic [4:0]        rd_q;
  logic              reg_write_q, mem_to_reg_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_q <= '0;
      mem_data_q   <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      if (bubble_i) begin
        reg_write_q  <= 1'b0;
        mem_to_reg_q <= 1'b0;
      end else begin
        alu_result_q <= alu_result_i;
        rd_q         <= rd_i;
        reg_write_q  <= reg_write_i;
        mem_to_reg_q <= mem_to_reg_i;
      end
      // Load data moves only on a completed read, never on a bubble or store.
      if (ld_data_i) begin
        mem_data_q <= mem_data_i;
      end
    end
  end

  assign alu_result_o = alu_result_q;
  assign mem_data_o   = mem_data_q;
  assign rd_o         = rd_q;
  assign reg_write_o  = reg_write_q;
  assign mem_to_reg_o = mem_to_reg_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues one word load/store at a time over a req/ack bus, stalls upstream
// while it is outstanding, and drives the MEM/WB register.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_rd2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic              mem_misaligned,
  output logic              mem_bus_error
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              misal_q, misal_d;
  logic              berr_q, berr_d;

  logic access, misaligned;
  logic stall, squash, ld_data;

  assign access     = ex_mem_read | ex_mem_write;
  assign misaligned = access & (|ex_alu_result[WORD_OFF_BITS-1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    misal_d = 1'b0;
    berr_d  = 1'b0;
    stall   = 1'b0;
    squash  = 1'b0;
    ld_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && !misaligned) begin
          // Bus lines are only written here so they stay quiet between accesses.
          stall   = 1'b1;
          addr_d  = ex_alu_result;
          wdata_d = ex_rd2;
          we_d    = ex_mem_write & ~ex_mem_read;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end else if (misaligned) begin
          squash  = 1'b1;
          misal_d = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          ld_data = ~we_q;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          squash  = 1'b1;
          berr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      misal_q <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      misal_q <= misal_d;
      berr_q  <= berr_d;
    end
  end

  assign mem_stall      = stall;
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign mem_misaligned = misal_q;
  assign mem_bus_error  = berr_q;

  // Upstream holds EX/MEM while stalled, so the ex_* fields still describe this access.
  mem_wb #(
    .DATA_W(DATA_W)
  ) u_mem_wb (
    .clk          (clk),
    .reset        (reset),
    .bubble_i     (stall),
    .ld_data_i    (ld_data),
    .alu_result_i (ex_alu_result),
    .mem_data_i   (dmem_rdata),
    .rd_i         (ex_rd),
    .reg_write_i  (ex_reg_write & ~squash),
    .mem_to_reg_i (ex_mem_to_reg),
    .alu_result_o (wb_alu_result),
    .mem_data_o   (wb_mem_data),
    .rd_o         (wb_rd),
    .reg_write_o  (wb_reg_write),
    .mem_to_reg_o (wb_mem_to_reg)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level model of MEM/WB contents.
module tb_mem_access_stage;

  localparam int DW = 32;
  localparam int T  = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] ex_alu_result, ex_rd2;
  logic [4:0]    ex_rd;
  logic          ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
  logic          mem_stall, dmem_req, dmem_we;
  logic [DW-1:0] dmem_addr, dmem_wdata;
  logic          dmem_ack;
  logic [DW-1:0] dmem_rdata;
  logic [DW-1:0] wb_alu_result, wb_mem_data;
  logic [4:0]    wb_rd;
  logic          wb_reg_write, wb_mem_to_reg, mem_misaligned, mem_bus_error;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model_mdata;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(DW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .ex_alu_result(ex_alu_result), .ex_rd2(ex_rd2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .mem_misaligned(mem_misaligned), .mem_bus_error(mem_bus_error)
  );

  // kind: 0 = non-memory, 1 = load, 2 = store, 3 = read+write (behaves as load).
  // ack_dly = WAIT cycles without ack before the ack cycle; >= T means never acked.
  // Entered and left at a negedge.
  task automatic do_op(input int kind, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                       input logic [4:0] rd, input logic rw, input logic m2r,
                       input int ack_dly, input logic [DW-1:0] rdata);
    logic misal, is_rd;
    int n;
    misal = (kind != 0) && (addr[1:0] != 2'b00);
    is_rd = (kind == 1) || (kind == 3);
    ex_alu_result = addr; ex_rd2 = wd; ex_rd = rd;
    ex_reg_write = rw; ex_mem_to_reg = m2r;
    ex_mem_read = is_rd; ex_mem_write = (kind == 2) || (kind == 3);
    dmem_ack = 1'b0;
    #1;
    if (kind == 0 || misal) begin
      checks++;
      if (mem_stall !== 1'b0) begin
        errors++; $display("FAIL stall_nomem got %b want 0", mem_stall);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if ({wb_alu_result, wb_rd, wb_reg_write, wb_mem_data, mem_misaligned, dmem_req}
          !== {addr, rd, (misal ? 1'b0 : rw), model_mdata, misal, 1'b0}) begin
        errors++;
        $display("FAIL wb_direct got alu=%h rd=%0d rw=%b md=%h mis=%b req=%b want alu=%h rd=%0d rw=%b md=%h mis=%b req=0",
                 wb_alu_result, wb_rd, wb_reg_write, wb_mem_data, mem_misaligned, dmem_req,
                 addr, rd, (misal ? 1'b0 : rw), model_mdata, misal);
      end
      if (!misal) begin
        checks++;
        if (wb_mem_to_reg !== m2r) begin
          errors++; $display("FAIL wb_m2r_direct got %b want %b", wb_mem_to_reg, m2r);
        end
      end
      return;
    end
    checks++;
    if (mem_stall !== 1'b1) begin
      errors++; $display("FAIL stall_issue got %b want 1", mem_stall);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_reg_write, wb_mem_to_reg}
        !== {1'b1, ~is_rd, addr, wd, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL bus_issue got req=%b we=%b addr=%h wd=%h rw=%b m2r=%b want req=1 we=%b addr=%h wd=%h rw=0 m2r=0",
               dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_reg_write, wb_mem_to_reg, ~is_rd, addr, wd);
    end
    n = (ack_dly < T) ? ack_dly : T;
    for (int i = 0; i < n; i++) begin
      #1;
      checks++;
      if ({mem_stall, dmem_req} !== {(i == T - 1) ? 1'b0 : 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL wait_cycle%0d got stall=%b req=%b want stall=%b req=1",
                 i, mem_stall, dmem_req, (i == T - 1) ? 1'b0 : 1'b1);
      end
      @(posedge clk); @(negedge clk);
      if (i != T - 1) begin
        checks++;
        if ({wb_reg_write, wb_mem_to_reg} !== 2'b00) begin
          errors++; $display("FAIL bubble%0d got rw=%b m2r=%b want 0 0", i, wb_reg_write, wb_mem_to_reg);
        end
      end
    end
    if (ack_dly >= T) begin
      checks++;
      if ({dmem_req, mem_bus_error, wb_reg_write, wb_alu_result, wb_rd, wb_mem_data}
          !== {1'b0, 1'b1, 1'b0, addr, rd, model_mdata}) begin
        errors++;
        $display("FAIL timeout got req=%b berr=%b rw=%b alu=%h rd=%0d md=%h want req=0 berr=1 rw=0 alu=%h rd=%0d md=%h",
                 dmem_req, mem_bus_error, wb_reg_write, wb_alu_result, wb_rd, wb_mem_data, addr, rd, model_mdata);
      end
    end else begin
      dmem_ack = 1'b1; dmem_rdata = rdata;
      #1;
      checks++;
      if ({mem_stall, dmem_req} !== 2'b01) begin
        errors++; $display("FAIL ack_cycle got stall=%b req=%b want stall=0 req=1", mem_stall, dmem_req);
      end
      @(posedge clk); @(negedge clk);
      dmem_ack = 1'b0;
      if (is_rd) model_mdata = rdata;
      checks++;
      if ({dmem_req, mem_bus_error, wb_alu_result, wb_rd, wb_reg_write, wb_mem_to_reg, wb_mem_data}
          !== {1'b0, 1'b0, addr, rd, rw, m2r, model_mdata}) begin
        errors++;
        $display("FAIL complete got req=%b berr=%b alu=%h rd=%0d rw=%b m2r=%b md=%h want req=0 berr=0 alu=%h rd=%0d rw=%b m2r=%b md=%h",
                 dmem_req, mem_bus_error, wb_alu_result, wb_rd, wb_reg_write, wb_mem_to_reg, wb_mem_data,
                 addr, rd, rw, m2r, model_mdata);
      end
    end
  endtask

  // One cycle with no operation; a stray ack here must be ignored.
  task automatic idle_gap();
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++; $display("FAIL gap_stall got %b want 0", mem_stall);
    end
    @(posedge clk); @(negedge clk);
    dmem_ack = 1'b0;
    checks++;
    if ({dmem_req, wb_reg_write, wb_mem_to_reg, mem_misaligned, mem_bus_error, wb_mem_data}
        !== {5'b0, model_mdata}) begin
      errors++;
      $display("FAIL gap got req=%b rw=%b m2r=%b mis=%b berr=%b md=%h want 0 0 0 0 0 md=%h",
               dmem_req, wb_reg_write, wb_mem_to_reg, mem_misaligned, mem_bus_error, wb_mem_data, model_mdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ex_alu_result = '0; ex_rd2 = '0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    model_mdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_alu_result, wb_mem_data, wb_rd,
         wb_reg_write, wb_mem_to_reg, mem_misaligned, mem_bus_error} !== '0) begin
      errors++;
      $display("FAIL reset_state got req=%b addr=%h wd=%h alu=%h md=%h rd=%0d rw=%b want all 0",
               dmem_req, dmem_addr, dmem_wdata, wb_alu_result, wb_mem_data, wb_rd, wb_reg_write);
    end
    reset = 1'b0;
  endtask

  task automatic test_nonmem();
    do_op(0, 32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 0, 32'h0);
    idle_gap();
  endtask

  task automatic test_load();
    do_op(1, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 3, 32'hDEADBEEF);
    idle_gap();
  endtask

  task automatic test_store();
    do_op(2, 32'h20, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 0, 32'h13572468);
    idle_gap();
  endtask

  task automatic test_misaligned();
    do_op(1, 32'h102, 32'h0, 5'd9, 1'b1, 1'b1, 0, 32'h0);
    idle_gap();
  endtask

  task automatic test_timeout();
    do_op(1, 32'h200, 32'h0, 5'd3, 1'b1, 1'b1, 100, 32'h0);
    idle_gap();
    do_op(0, 32'h55, 32'h0, 5'd4, 1'b1, 1'b0, 0, 32'h0);
    idle_gap();
  endtask

  task automatic test_reset_mid_wait();
    ex_alu_result = 32'h40; ex_rd2 = '0; ex_rd = 5'd6;
    ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b1;
    @(posedge clk); @(negedge clk);
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
    reset = 1'b1;
    #1;
    model_mdata = '0;
    checks++;
    if ({dmem_req, wb_alu_result, wb_mem_data, wb_rd, wb_reg_write, wb_mem_to_reg} !== '0) begin
      errors++;
      $display("FAIL reset_mid_wait got req=%b alu=%h md=%h rd=%0d rw=%b m2r=%b want all 0",
               dmem_req, wb_alu_result, wb_mem_data, wb_rd, wb_reg_write, wb_mem_to_reg);
    end
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    do_op(1, 32'h44, 32'h0, 5'd8, 1'b1, 1'b1, 1, 32'hCAFEF00D);
    idle_gap();
  endtask

  task automatic test_back_to_back();
    int kind, dly;
    logic [DW-1:0] addr;
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 3);
      addr = $urandom & ~32'h3;
      if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      dly = ($urandom_range(0, 9) == 0) ? T + 2 : $urandom_range(0, 4);
      do_op(kind, addr, $urandom, 5'($urandom), 1'($urandom), 1'($urandom), dly, $urandom);
      if ($urandom_range(0, 2) == 0) idle_gap();
    end
    idle_gap();
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_nonmem();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
